serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Multi-cycle, parametrised adder/subtractor. It processes WIDTH-bit operands CHUNK bits per clock through a
//   registered carry, so a wide add costs cycles instead of a long ripple chain. It is the sequential successor
//   of the 1-bit full-adder cell, adds subtract mode and status flags, and feeds the ALU/accumulator datapath.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 2
//   CHUNK  1  bits summed per clock; must divide WIDTH; N = WIDTH/CHUNK is the number of compute cycles
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   start_i   in   1      request; sampled only while busy_o=0
//   sub_i     in   1      0: a+b; 1: a-b; sampled with start_i
//   a_i       in   WIDTH  operand A; sampled with start_i
//   b_i       in   WIDTH  operand B; sampled with start_i
//   busy_o    out  1      operation in progress
//   done_o    out  1      one-cycle pulse: result/flags valid
//   result_o  out  WIDTH  sum/difference; held until next accepted start
//   carry_o   out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf_o     out  1      signed two's-complement overflow
//   zero_o    out  1      result_o == 0
// BEHAVIOUR
//   Interface: one clock clk; reset is asynchronous and active-low (rst_n).
//   Reset (rst_n=0, async): state=IDLE; busy_o=0, done_o=0, result_o=0, carry_o=0, ovf_o=0, zero_o=0;
//     the chunk counter and operand shift registers are cleared. Reset mid-operation aborts the operation
//     with no done_o; the first accepted start after release behaves normally.
//   FSM states: IDLE, RUN, DONE.
//     IDLE/DONE --start_i--> RUN: at edge E0, latch a_i; latch b_i ^ {WIDTH{sub_i}}; set carry reg = sub_i;
//       set cnt = 0; set busy_o = 1.
//     RUN: edge Ek (k = 1..N) adds chunk k-1 (LSB chunk first) plus the carry reg. The CHUNK sum bits shift
//       into the result reg and the carry reg is updated.
//     RUN --cnt==N-1--> DONE at edge EN: result_o, carry_o, ovf_o and zero_o update; busy_o drops; done_o rises.
//     DONE --no start--> IDLE at EN+1; done_o falls. Outputs are held.
//   Latency: done_o is high during the cycle after EN, i.e. N cycles after the start edge (N=8 for defaults).
//   Throughput: back-to-back is allowed. A start_i sampled while done_o=1 is accepted, giving one op every N+1 cycles.
//   start_i while busy_o=1 is ignored: no queueing, and the operation in flight is not disturbed.
//   Operand inputs may change freely after E0; only the latched copies are used.
//   ovf_o = (A[MSB] == B'[MSB]) && (R[MSB] != A[MSB]), where B' is the inverted-if-sub operand.
//   Width rule: result is modulo 2^WIDTH. Only carry_o exposes bit WIDTH.
//   result_o and flags change only at EN; they are stable from then until the EN of the next operation.
// STRUCTURE
//   Shared package add_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2); the width of the chunk
//     counter, computed as clog2 of N.
//   Sub-module fa_slice #(CHUNK): combinational CHUNK-bit ripple of full-adder cells
//     (a, b, cin -> s, cout), instantiated once.
//   Top level: FSM, counter, operand/result shift registers, flag logic.
// TESTING
//   WIDTH=8,CHUNK=1: A=0x7F,B=0x01,sub=0 -> done_o 8 cycles after start; result 0x80, carry 0, ovf 1, zero 0.
//   WIDTH=8,CHUNK=1: A=0xFF,B=0x01,sub=0 -> result 0x00, carry 1, ovf 0, zero 1.
//   WIDTH=8,CHUNK=1: A=0x00,B=0x01,sub=1 -> result 0xFF, carry 0 (borrow), ovf 0. A=0x80,B=0x01,sub=1 -> 0x7F, ovf 1.
//   Pulse start_i with A=0x11 three cycles into a busy op -> ignored. The first op's result is unchanged and
//     done_o pulses exactly once.
//   Assert rst_n=0 at cycle 4 of RUN -> all outputs 0 immediately and no done_o. After release,
//     0x05+0x03 -> 0x08.
//   WIDTH=8,CHUNK=4: 0x3C+0x4B -> result 0x87, ovf 1, done_o 2 cycles after start. Issue back-to-back starts
//     -> one done every 3 cycles.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding and
// the sizing helper for its chunk counter.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // clog2 of the number of compute cycles, kept at least 1 bit wide
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational CHUNK-bit ripple of full-adder cells; the only adder hardware
// in the serial datapath.
module fa_slice #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: sums WIDTH-bit operands CHUNK bits per clock
// through a registered carry, then publishes the result and status flags.
module serial_addsub
    import add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(WIDTH, CHUNK);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             last;

    fa_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (cy),
        .s    (sum),
        .cout (cout)
    );

    // Sum chunks enter at the top so the LSB chunk ends up at the bottom after N shifts
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign acc_next = sum;
        end else begin : g_multi
            assign acc_next = {sum, acc[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            carry_o  <= 1'b0;
            ovf_o    <= 1'b0;
            zero_o   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i ^ {WIDTH{sub_i}};
                        cy     <= sub_i;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> CHUNK;
                    b_sh <= b_sh >> CHUNK;
                    cy   <= cout;
                    acc  <= acc_next;
                    cnt  <= cnt + 1'b1;
                    // On the top chunk the slice inputs/outputs carry the MSBs for the overflow rule
                    if (last) begin
                        result_o <= acc_next;
                        carry_o  <= cout;
                        ovf_o    <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                                    (sum[CHUNK-1] != a_sh[CHUNK-1]);
                        zero_o   <= (acc_next == '0);
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: one instance with CHUNK=1 and one
// with CHUNK=4, driven from a vector table, random operands and corner sequences.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1 = 1'b0, sub1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0;
    logic       busy1, done1, carry1, ovf1, zero1;
    logic [7:0] res1;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, carry4, ovf4, zero4;
    logic [7:0] res4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .sub_i(sub1), .a_i(a1), .b_i(b1),
        .busy_o(busy1), .done_o(done1), .result_o(res1), .carry_o(carry1),
        .ovf_o(ovf1), .zero_o(zero1)
    );

    serial_addsub #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .sub_i(sub4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .result_o(res4), .carry_o(carry4),
        .ovf_o(ovf4), .zero_o(zero4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       carry;
        logic       ovf;
        logic       zero;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, {carry, ovf, zero, result}
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub);
        int ua, ub, ur, sa, sb, sr;
        logic [7:0] r;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = sub ? (ua - ub) : (ua + ub);
        sr = sub ? (sa - sb) : (sa + sb);
        r  = 8'(ur & 255);
        c  = sub ? (ua >= ub) : (ur > 255);
        o  = (sr > 127) || (sr < -128);
        return {c, o, (r == 8'h00), r};
    endfunction

    // Issues one op on the chosen instance; lat counts edges from the start edge to done
    task automatic applyStimulus(input int which, input logic [7:0] a, input logic [7:0] b,
                                 input logic sub, output logic [7:0] res, output logic c,
                                 output logic o, output logic z, output int lat);
        @(negedge clk);
        if (which == 1) begin a1 = a; b1 = b; sub1 = sub; start1 = 1'b1; end
        else            begin a4 = a; b4 = b; sub4 = sub; start4 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom);
        a4 = 8'($urandom); b4 = 8'($urandom); sub4 = 1'($urandom);
        lat = 0;
        while (!((which == 1) ? done1 : done4) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (which == 1) begin res = res1; c = carry1; o = ovf1; z = zero1; end
        else            begin res = res4; c = carry4; o = ovf4; z = zero4; end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [7:0]  r;
        logic        c, o, z;
        int          lat, n_exp, cnt_done, first_done;
        logic [10:0] exp_v;
        logic [31:0] mask;
        logic [7:0]  ra, rb;
        logic        rs;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("reset outputs x1", 32'({busy1, done1, res1, carry1, ovf1, zero1}), 32'h0);
        checkOutput("reset outputs x4", 32'({busy4, done4, res4, carry4, ovf4, zero4}), 32'h0);
        rst_n = 1'b1;

        // Spec vectors on both chunk sizes
        for (int w = 0; w < 2; w++) begin
            n_exp = (w == 0) ? 8 : 2;
            for (int i = 0; i < 6; i++) begin
                applyStimulus((w == 0) ? 1 : 4, vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o, z, lat);
                checkOutput($sformatf("vec%0d/w%0d result", i, w), 32'(r), 32'(vecs[i].res));
                checkOutput($sformatf("vec%0d/w%0d carry", i, w), 32'(c), 32'(vecs[i].carry));
                checkOutput($sformatf("vec%0d/w%0d ovf", i, w), 32'(o), 32'(vecs[i].ovf));
                checkOutput($sformatf("vec%0d/w%0d zero", i, w), 32'(z), 32'(vecs[i].zero));
                checkOutput($sformatf("vec%0d/w%0d latency", i, w), 32'(lat), 32'(n_exp));
            end
        end

        // Random operands against the integer model
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            exp_v = model(ra, rb, rs);
            applyStimulus((i % 2 == 0) ? 1 : 4, ra, rb, rs, r, c, o, z, lat);
            checkOutput($sformatf("rand%0d flags+result", i), 32'({c, o, z, r}), 32'(exp_v));
            checkOutput($sformatf("rand%0d latency", i), 32'(lat), (i % 2 == 0) ? 32'd8 : 32'd2);
        end

        // Start pulse while busy must be ignored
        @(negedge clk);
        a1 = 8'h12; b1 = 8'h34; sub1 = 1'b0; start1 = 1'b1;
        cnt_done = 0;
        first_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done1) begin
                cnt_done++;
                if (first_done == 0) first_done = i;
            end
            if (i == 1) start1 = 1'b0;
            if (i == 3) begin a1 = 8'h11; b1 = 8'h00; start1 = 1'b1; end
            if (i == 4) start1 = 1'b0;
        end
        checkOutput("ignore: done pulse count", 32'(cnt_done), 32'd1);
        checkOutput("ignore: done position", 32'(first_done), 32'd9);
        checkOutput("ignore: result", 32'(res1), 32'h46);

        // Reset in the middle of RUN aborts without a done pulse
        applyStimulus(1, 8'h7F, 8'h01, 1'b0, r, c, o, z, lat);
        checkOutput("pre-reset result", 32'(r), 32'h80);
        @(negedge clk);
        a1 = 8'h40; b1 = 8'h40; sub1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre-reset busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-op reset outputs", 32'({busy1, done1, res1, carry1, ovf1, zero1}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done1) cnt_done++;
        end
        checkOutput("no done after abort", 32'(cnt_done), 32'd0);
        applyStimulus(1, 8'h05, 8'h03, 1'b0, r, c, o, z, lat);
        checkOutput("post-reset result", 32'(r), 32'h08);
        checkOutput("post-reset latency", 32'(lat), 32'd8);

        // Back-to-back starts on the CHUNK=4 instance: one done every 3 cycles
        @(negedge clk);
        a4 = 8'h3C; b4 = 8'h4B; sub4 = 1'b0; start4 = 1'b1;
        mask = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 7) start4 = 1'b0;
            mask[i] = done4;
            if (done4) begin
                checkOutput($sformatf("b2b result @%0d", i), 32'(res4), 32'h87);
                checkOutput($sformatf("b2b ovf @%0d", i), 32'(ovf4), 32'd1);
            end
        end
        checkOutput("b2b done pattern", mask, 32'h248);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
